// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK/DONT_WALK controller for the NS and WE crosswalks, slaved to the traffic-light lamp codes.
// Latency: WALK lights the edge after the first green cycle; a button reaches req_* two edges after it is sampled.
// Backpressure: none; a request that misses a green (or is pressed mid-walk) is held for the next green onset.

module ped_chan #(
  parameter int WALK_CYCLES  = 6,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_HALF   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [2:0] led,
  input  logic       green,
  input  logic       illegal_any,
  input  logic       fault,
  output logic       walk,
  output logic       dontwalk,
  output logic       req,
  output logic [3:0] cnt,
  output logic       kill
);

  localparam int WW = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [WW-1:0] WALK_LAST  = WW'(WALK_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(FLASH_HALF - 1);
  localparam logic [3:0]    FLASH_LOAD = 4'(FLASH_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WALK  = 2'd1;
  localparam logic [1:0] S_FLASH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic          btn_s1, btn_s2;
  logic [2:0]    led_prev;
  logic [1:0]    state;
  logic [WW-1:0] wtmr;
  logic [HW-1:0] htmr;
  logic [3:0]    cnt_r;
  logic          ph;
  logic          onset, stop, enter;

  // Green onset is a rising edge of the raw lamp code; any non-green or illegal code ends a walk.
  assign onset = green && (led_prev != 3'b001);
  assign stop  = !green || illegal_any;
  assign kill  = ((state == S_WALK) || (state == S_FLASH)) && stop && !fault;
  assign enter = (state == S_IDLE) && onset && req && !illegal_any && !fault;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Request latch: consumed on entry to WALK, a press landing on that same edge survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req <= 1'b0;
    else     req <= (req & ~enter) | btn_s2;
  end

  // Previous lamp code for green-onset detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_prev <= 3'b100;
    else     led_prev <= led;
  end

  // Channel sequencer: IDLE -> WALK -> FLASH -> DONE, with abort back to IDLE on loss of green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wtmr  <= '0;
      htmr  <= '0;
      cnt_r <= 4'd0;
      ph    <= 1'b0;
    end else if (fault) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enter) begin
            state <= S_WALK;
            wtmr  <= WALK_LAST;
          end
        end
        S_WALK: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (wtmr == '0) begin
            state <= S_FLASH;
            cnt_r <= FLASH_LOAD;
            ph    <= 1'b1;
            htmr  <= HALF_LAST;
          end else begin
            wtmr <= wtmr - 1'b1;
          end
        end
        S_FLASH: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (cnt_r == 4'd1) begin
            state <= S_DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (htmr == '0) begin
              ph   <= ~ph;
              htmr <= HALF_LAST;
            end else begin
              htmr <= htmr - 1'b1;
            end
          end
        end
        default: begin
          if (stop) state <= S_IDLE;
        end
      endcase
    end
  end

  // Lamp decode; a latched fault pins the crosswalk to DONT_WALK.
  always_comb begin
    walk     = 1'b0;
    dontwalk = 1'b1;
    cnt      = 4'd0;
    if (!fault) begin
      if (state == S_WALK) begin
        walk     = 1'b1;
        dontwalk = 1'b0;
      end else if (state == S_FLASH) begin
        dontwalk = ph;
        cnt      = cnt_r;
      end
    end
  end

endmodule

module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 6,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_HALF   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] led_ns,
  input  logic [2:0] led_we,
  input  logic       btn_ns,
  input  logic       btn_we,
  output logic       walk_ns,
  output logic       dontwalk_ns,
  output logic       walk_we,
  output logic       dontwalk_we,
  output logic       req_ns,
  output logic       req_we,
  output logic [3:0] cnt_ns,
  output logic [3:0] cnt_we,
  output logic       abort,
  output logic       fault
);

  logic both_green, illegal_any, green_ns, green_we, kill_ns, kill_we;

  function automatic logic legal_code(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  // Both greens at once is treated as illegal on both channels, which also keeps the walks exclusive.
  assign both_green  = (led_ns == 3'b001) && (led_we == 3'b001);
  assign illegal_any = !legal_code(led_ns) || !legal_code(led_we) || both_green;
  assign green_ns    = (led_ns == 3'b001) && !both_green;
  assign green_we    = (led_we == 3'b001) && !both_green;

  ped_chan #(.WALK_CYCLES(WALK_CYCLES), .FLASH_CYCLES(FLASH_CYCLES), .FLASH_HALF(FLASH_HALF)) u_ns (
    .clk(clk), .rst(rst), .btn(btn_ns), .led(led_ns), .green(green_ns),
    .illegal_any(illegal_any), .fault(fault),
    .walk(walk_ns), .dontwalk(dontwalk_ns), .req(req_ns), .cnt(cnt_ns), .kill(kill_ns)
  );

  ped_chan #(.WALK_CYCLES(WALK_CYCLES), .FLASH_CYCLES(FLASH_CYCLES), .FLASH_HALF(FLASH_HALF)) u_we (
    .clk(clk), .rst(rst), .btn(btn_we), .led(led_we), .green(green_we),
    .illegal_any(illegal_any), .fault(fault),
    .walk(walk_we), .dontwalk(dontwalk_we), .req(req_we), .cnt(cnt_we), .kill(kill_we)
  );

  // Sticky fault on any illegal lamp code; single abort pulse even if both channels are cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
      abort <= 1'b0;
    end else begin
      fault <= fault | illegal_any;
      abort <= kill_ns | kill_we;
    end
  end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Self-checking bench for ped_signal_ctrl: hand-written vector table, directed corner sequences and random light traffic.
// Latency: checks sampled on the falling edge, reference model advanced on each rising edge.
// Backpressure: not applicable; stimulus is free-running.

module tb_ped_signal_ctrl;

  localparam int W = 6;
  localparam int F = 6;
  localparam int H = 1;
  localparam int MD_IDLE = 0;
  localparam int MD_SEQ  = 1;
  localparam int MD_DONE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] led_ns, led_we;
  logic       btn_ns, btn_we;
  logic       walk_ns, dontwalk_ns, walk_we, dontwalk_we;
  logic       req_ns, req_we, abort, fault;
  logic [3:0] cnt_ns, cnt_we;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Reference model: per channel a mode and the age (cycles since the walk began).
  int         m_mode[2];
  int         m_age[2];
  bit         m_req[2];
  logic [2:0] m_prev[2];
  bit         m_fault;
  bit         m_abort;
  bit         q_ns[$];
  bit         q_we[$];

  typedef struct {
    logic [2:0] ns;
    logic [2:0] we;
    bit         bn;
    bit         w;
    bit         dw;
    int         cnt;
    bit         rq;
  } row_t;
  row_t tbl[21];

  ped_signal_ctrl dut (
    .clk(clk), .rst(rst), .led_ns(led_ns), .led_we(led_we), .btn_ns(btn_ns), .btn_we(btn_we),
    .walk_ns(walk_ns), .dontwalk_ns(dontwalk_ns), .walk_we(walk_we), .dontwalk_we(dontwalk_we),
    .req_ns(req_ns), .req_we(req_we), .cnt_ns(cnt_ns), .cnt_we(cnt_we), .abort(abort), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc_n);
    end
  endtask

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = MD_IDLE;
      m_age[c]  = 0;
      m_req[c]  = 1'b0;
      m_prev[c] = 3'b100;
    end
    m_fault = 1'b0;
    m_abort = 1'b0;
    q_ns.delete();
    q_we.delete();
  endtask

  // Expected lamps for a channel derived from how long its walk has been running.
  function automatic void exp_ch(input int c, output bit w, output bit dw, output int cn);
    int fl;
    w  = 1'b0;
    dw = 1'b1;
    cn = 0;
    if (!m_fault && m_mode[c] == MD_SEQ) begin
      if (m_age[c] < W) begin
        w  = 1'b1;
        dw = 1'b0;
      end else begin
        fl = m_age[c] - W;
        dw = ((fl / H) % 2) == 0;
        cn = F - fl;
      end
    end
  endfunction

  task automatic model_step();
    logic [2:0] led[2];
    bit         dly[2];
    bit         grn;
    bit         both, ill, onset, enter;
    led[0] = led_ns;
    led[1] = led_we;
    dly[0] = (q_ns.size() >= 2) ? q_ns[q_ns.size()-2] : 1'b0;
    dly[1] = (q_we.size() >= 2) ? q_we[q_we.size()-2] : 1'b0;
    both   = (led_ns == 3'b001) && (led_we == 3'b001);
    ill    = !legal(led_ns) || !legal(led_we) || both;
    m_abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      grn   = (led[c] == 3'b001) && !both;
      onset = grn && (m_prev[c] != 3'b001);
      enter = 1'b0;
      if (m_fault) begin
        m_mode[c] = MD_IDLE;
      end else if (m_mode[c] == MD_SEQ) begin
        if (!grn || ill) begin
          m_mode[c] = MD_IDLE;
          m_abort   = 1'b1;
        end else begin
          m_age[c]++;
          if (m_age[c] == W + F) m_mode[c] = MD_DONE;
        end
      end else if (m_mode[c] == MD_DONE) begin
        if (!grn || ill) m_mode[c] = MD_IDLE;
      end else if (onset && m_req[c] && !ill) begin
        m_mode[c] = MD_SEQ;
        m_age[c]  = 0;
        enter     = 1'b1;
      end
      m_req[c]  = (m_req[c] && !enter) || dly[c];
      m_prev[c] = led[c];
    end
    m_fault = m_fault || ill;
    q_ns.push_back(btn_ns);
    q_we.push_back(btn_we);
    if (q_ns.size() > 2) void'(q_ns.pop_front());
    if (q_we.size() > 2) void'(q_we.pop_front());
  endtask

  task automatic compare_model();
    bit w, dw;
    int cn;
    exp_ch(0, w, dw, cn);
    chk("walk_ns", walk_ns, w);
    chk("dontwalk_ns", dontwalk_ns, dw);
    chk("cnt_ns", cnt_ns, cn);
    chk("req_ns", req_ns, m_req[0]);
    exp_ch(1, w, dw, cn);
    chk("walk_we", walk_we, w);
    chk("dontwalk_we", dontwalk_we, dw);
    chk("cnt_we", cnt_we, cn);
    chk("req_we", req_we, m_req[1]);
    chk("abort", abort, m_abort);
    chk("fault", fault, m_fault);
    chk("mutex", walk_ns & walk_we, 0);
  endtask

  task automatic apply(input logic [2:0] ns, input logic [2:0] we, input bit bn, input bit bw);
    led_ns = ns;
    led_we = we;
    btn_ns = bn;
    btn_we = bw;
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic phase(input logic [2:0] ns, input logic [2:0] we, input int n,
                       input bit bn, input bit bw, input bit idle_chk);
    for (int i = 0; i < n; i++) begin
      apply(ns, we, bn, bw);
      settle();
      if (idle_chk) begin
        chk("A_walk_ns", walk_ns, 0);
        chk("A_walk_we", walk_we, 0);
        chk("A_dw_ns", dontwalk_ns, 1);
        chk("A_dw_we", dontwalk_we, 1);
        chk("A_fault", fault, 0);
      end
      advance();
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    apply(3'b100, 3'b100, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    chk("rst_walk_ns", walk_ns, 0);
    chk("rst_dw_ns", dontwalk_ns, 1);
    chk("rst_dw_we", dontwalk_we, 1);
    chk("rst_fault", fault, 0);
    chk("rst_req_ns", req_ns, 0);
    compare_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{3'b100, 3'b001, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[1]  = '{3'b100, 3'b001, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[2]  = '{3'b100, 3'b001, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[3]  = '{3'b100, 3'b010, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[4]  = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[5]  = '{3'b001, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    for (int i = 6; i < 12; i++) tbl[i] = '{3'b001, 3'b100, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    for (int i = 12; i < 18; i++) tbl[i] = '{3'b001, 3'b100, 1'b0, 1'b0, ((i - 12) % 2) == 0, 18 - i, 1'b0};
    tbl[18] = '{3'b001, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[19] = '{3'b010, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[20] = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b0};

    rst = 1'b1;
    apply(3'b100, 3'b100, 1'b0, 1'b0);
    model_reset();
    #2;
    do_reset();

    // A: two full light cycles with no buttons.
    for (int k = 0; k < 2; k++) begin
      phase(3'b001, 3'b100, 15, 1'b0, 1'b0, 1'b1);
      phase(3'b010, 3'b100, 3, 1'b0, 1'b0, 1'b1);
      phase(3'b100, 3'b100, 3, 1'b0, 1'b0, 1'b1);
      phase(3'b100, 3'b001, 15, 1'b0, 1'b0, 1'b1);
      phase(3'b100, 3'b010, 3, 1'b0, 1'b0, 1'b1);
      phase(3'b100, 3'b100, 3, 1'b0, 1'b0, 1'b1);
    end

    // Table: one-cycle press during WE green, then a full NS walk.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].ns, tbl[i].we, tbl[i].bn, 1'b0);
      settle();
      chk("T_walk_ns", walk_ns, tbl[i].w);
      chk("T_dw_ns", dontwalk_ns, tbl[i].dw);
      chk("T_cnt_ns", cnt_ns, tbl[i].cnt);
      chk("T_req_ns", req_ns, tbl[i].rq);
      advance();
    end

    // B: green cut short after 4 cycles.
    do_reset();
    phase(3'b100, 3'b001, 1, 1'b1, 1'b0, 1'b0);
    phase(3'b100, 3'b001, 4, 1'b0, 1'b0, 1'b0);
    apply(3'b100, 3'b100, 1'b0, 1'b0); settle(); chk("B_req", req_ns, 1); advance();
    phase(3'b001, 3'b100, 4, 1'b0, 1'b0, 1'b0);
    apply(3'b010, 3'b100, 1'b0, 1'b0); settle(); chk("B_walk_last", walk_ns, 1); advance();
    apply(3'b010, 3'b100, 1'b0, 1'b0); settle();
    chk("B_walk_off", walk_ns, 0);
    chk("B_abort", abort, 1);
    chk("B_dw", dontwalk_ns, 1);
    chk("B_cnt", cnt_ns, 0);
    advance();
    apply(3'b100, 3'b100, 1'b0, 1'b0); settle();
    chk("B_abort_end", abort, 0);
    chk("B_req_lost", req_ns, 0);
    advance();

    // C: button held through a whole walk gives a second walk.
    do_reset();
    phase(3'b100, 3'b001, 4, 1'b1, 1'b0, 1'b0);
    phase(3'b001, 3'b100, 16, 1'b1, 1'b0, 1'b0);
    apply(3'b001, 3'b100, 1'b0, 1'b0); settle();
    chk("C_req_relatch", req_ns, 1);
    chk("C_done_walk", walk_ns, 0);
    advance();
    phase(3'b010, 3'b100, 3, 1'b0, 1'b0, 1'b0);
    phase(3'b100, 3'b001, 5, 1'b0, 1'b0, 1'b0);
    apply(3'b001, 3'b100, 1'b0, 1'b0); settle(); chk("C_onset_walk", walk_ns, 0); advance();
    apply(3'b001, 3'b100, 1'b0, 1'b0); settle(); chk("C_second_walk", walk_ns, 1); advance();

    // D: one illegal WE code latches fault and blocks walks until reset.
    do_reset();
    phase(3'b100, 3'b011, 1, 1'b0, 1'b0, 1'b0);
    apply(3'b100, 3'b001, 1'b1, 1'b0); settle(); chk("D_fault", fault, 1); advance();
    phase(3'b100, 3'b001, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(3'b001, 3'b100, 1'b0, 1'b0); settle();
      chk("D_no_walk", walk_ns, 0);
      chk("D_dw", dontwalk_ns, 1);
      advance();
    end
    do_reset();

    // E: asynchronous reset in the middle of FLASH.
    phase(3'b100, 3'b001, 1, 1'b1, 1'b0, 1'b0);
    phase(3'b100, 3'b001, 3, 1'b0, 1'b0, 1'b0);
    phase(3'b100, 3'b100, 1, 1'b0, 1'b0, 1'b0);
    phase(3'b001, 3'b100, 1, 1'b0, 1'b1, 1'b0);
    phase(3'b001, 3'b100, 9, 1'b0, 1'b0, 1'b0);
    apply(3'b001, 3'b100, 1'b0, 1'b0); settle();
    chk("E_cnt3", cnt_ns, 3);
    chk("E_req_we", req_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("E_walk_ns", walk_ns, 0);
    chk("E_dw_ns", dontwalk_ns, 1);
    chk("E_cnt_ns", cnt_ns, 0);
    chk("E_req_ns", req_ns, 0);
    chk("E_req_we", req_we, 0);
    chk("E_walk_we", walk_we, 0);
    chk("E_dw_we", dontwalk_we, 1);
    chk("E_abort", abort, 0);
    chk("E_fault", fault, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random legal light traffic with random button presses.
    for (int k = 0; k < 40; k++) begin
      int gn, yn, rn, gw, yw, rw;
      gn = $urandom_range(1, 20); yn = $urandom_range(1, 3); rn = $urandom_range(1, 3);
      gw = $urandom_range(1, 20); yw = $urandom_range(1, 3); rw = $urandom_range(1, 3);
      for (int i = 0; i < gn + yn + rn + gw + yw + rw; i++) begin
        logic [2:0] ns, we;
        ns = 3'b100;
        we = 3'b100;
        if (i < gn) ns = 3'b001;
        else if (i < gn + yn) ns = 3'b010;
        else if (i >= gn + yn + rn && i < gn + yn + rn + gw) we = 3'b001;
        else if (i >= gn + yn + rn + gw && i < gn + yn + rn + gw + yw) we = 3'b010;
        phase(ns, we, 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b0);
      end
    end

    // Random raw lamp codes, illegal ones included.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ns, we;
      ns = 3'($urandom_range(0, 7));
      we = 3'($urandom_range(0, 7));
      phase(ns, we, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Pedestrian crossing controller directly downstream of the traffic-light FSM.
- Consumes the NS and WE lamp codes (100 = red, 010 = yellow, 001 = green) and pedestrian push-buttons.
- Drives WALK / DONT_WALK lamps and a flash countdown for the two crosswalks.
- Crosswalk NS walks only during NS green; crosswalk WE walks only during WE green.

Parameters:
- WALK_CYCLES, 6: cycles of steady WALK after green onset.
- FLASH_CYCLES, 6: cycles of flashing DONT_WALK after WALK; max 15.
- FLASH_HALF, 1: cycles per flash half-period.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- led_ns  in  3  NS lamp code from the traffic-light FSM.
- led_we  in  3  WE lamp code from the traffic-light FSM.
- btn_ns  in  1  NS crosswalk button, asynchronous level.
- btn_we  in  1  WE crosswalk button, asynchronous level.
- walk_ns  out  1  NS WALK lamp.
- dontwalk_ns  out  1  NS DONT_WALK lamp.
- walk_we  out  1  WE WALK lamp.
- dontwalk_we  out  1  WE DONT_WALK lamp.
- req_ns  out  1  NS request latched.
- req_we  out  1  WE request latched.
- cnt_ns  out  4  NS flash countdown.
- cnt_we  out  4  WE flash countdown.
- abort  out  1  one-cycle pulse: a walk sequence was cut short.
- fault  out  1  sticky illegal lamp code seen.

Behaviour:
- Reset values:
  - All outputs 0 except dontwalk_ns = dontwalk_we = 1.
  - Both channel FSMs in IDLE.
  - Synchronisers cleared.
  - led_*_prev = 100.
- Two identical channels; X denotes ns or we, each using its own led_X.
- Button path:
  - 2-flop synchroniser per button.
  - The synced level sets req_X, so req_X rises 2 edges after btn_X is high at an edge.
  - req_X holds until cleared on entry to WALK.
  - A press during WALK/FLASH/DONE is latched and serves the next green.
- Green onset: led_X == 001 and led_X_prev != 001; led_X_prev is registered every cycle.
- Channel FSM:
  - IDLE: walk 0, dontwalk 1, cnt 0.
    - Onset with req_X = 1 -> WALK, req_X cleared.
    - walk_X = 1 from the edge after the first green cycle.
  - WALK: walk 1, dontwalk 0 for WALK_CYCLES cycles -> FLASH.
  - FLASH: walk 0, dontwalk flashes for FLASH_CYCLES cycles -> DONE.
    - dontwalk is 1 on the first FLASH cycle and toggles every FLASH_HALF cycles.
    - cnt_X = FLASH_CYCLES on the first FLASH cycle, decrements by 1 per cycle, and reaches 1 on the last.
  - DONE: walk 0, dontwalk 1, cnt 0; stays until led_X != 001, then -> IDLE.
- Safety abort:
  - If led_X != 001 while in WALK or FLASH: next edge -> IDLE, walk 0, dontwalk 1, cnt 0.
  - abort pulses high for 1 cycle.
  - A request consumed by the aborted walk is not restored.
- Illegal code: a led value outside {100, 010, 001} counts as not-green and sets fault (sticky until rst).
  - While fault = 1, both channels are forced to IDLE outputs.
  - Requests are still latched but never served.
- Mutual exclusion: walk_ns and walk_we are never both 1.
  - If both led inputs are 001 in one cycle, this is an illegal code for both: fault is set.
- Simultaneous events:
  - Abort on both channels in the same cycle gives one abort pulse.
  - Onset and button press in the same cycle: the onset does not see the press; it serves the next green.
- rst mid-sequence returns everything to reset values immediately (asynchronously); pending requests are lost.

Test Plan:
- Drive the upstream light sequence (NS green 15, yellow 3, red-red 3, WE green 15, yellow 3, red-red 3) with no buttons -> walk_* stays 0, dontwalk_* stays 1, fault 0.
- Pulse btn_ns for 1 cycle during WE green, then NS green onset at cycle T:
  - req_ns = 1 before T.
  - walk_ns = 1 for cycles T+1..T+6.
  - dontwalk_ns pattern 1,0,1,0,1,0 and cnt_ns 6,5,4,3,2,1 for cycles T+7..T+12.
  - Then DONE; req_ns = 0.
- btn_ns held through an entire NS walk -> req_ns re-latched, and a second walk occurs at the next NS green onset.
- Request latched, then NS green lasting only 4 cycles -> walk_ns is 0 at the first non-green cycle + 1, abort is one 1-cycle pulse, dontwalk_ns = 1, cnt_ns = 0.
- led_we = 011 for 1 cycle -> fault = 1 permanently.
  - A later request with green onset produces no walk.
  - rst clears fault and dontwalk_* = 1.
- Assert rst during NS FLASH with cnt_ns = 3 -> all outputs at reset values before the next clk edge; req_* = 0.
